// File: rtl/serial_frame_fifo.sv
// rtl/serial_frame_fifo.sv - Pi serial deserialiser feeding a frame FIFO for the I2S output stage
module serial_frame_fifo #(
    parameter int SAMPLE_W   = 16,
    parameter int CHANNELS   = 2,
    parameter int DEPTH_LOG2 = 6,
    parameter int LOW_WATER  = 16,
    parameter int HIGH_WATER = 48
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rpi_clk,
    input  logic                           serial,
    input  logic                           enable,
    input  logic                           ready,
    output logic                           rpi_interrupt,
    output logic [SAMPLE_W*CHANNELS-1:0]   data,
    output logic [DEPTH_LOG2:0]            level,
    output logic                           underrun,
    output logic                           overrun
);
    localparam int FRAME_W = SAMPLE_W * CHANNELS;
    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LOW_LVL  = (DEPTH_LOG2 + 1)'(LOW_WATER);
    localparam logic [DEPTH_LOG2:0] HIGH_LVL = (DEPTH_LOG2 + 1)'(HIGH_WATER);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {ST_DISABLED, ST_PRIME, ST_RUN} state_t;
    state_t state, state_next;

    logic [2:0]            rpi_sync;
    logic [1:0]            ser_sync;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_W-1:0]    frame_sr;
    logic [FRAME_W-1:0]    push_frame;
    logic                  push_pending;
    logic                  ready_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [FRAME_W-1:0]    mem [DEPTH];

    logic rpi_rise, shift_active, pop_req, empty, full;
    logic pop_take, underrun_set, push_ok, overrun_set;

    assign rpi_rise     = rpi_sync[1] & ~rpi_sync[2];
    assign shift_active = enable && (state != ST_DISABLED);
    assign pop_req      = ready & ~ready_q;
    assign empty        = (level == '0);
    assign full         = (level == FULL_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpi_sync <= '0;
            ser_sync <= '0;
        end else begin
            rpi_sync <= {rpi_sync[1:0], rpi_clk};
            ser_sync <= {ser_sync[0], serial};
        end
    end

    // The whole frame shifts left, so the first sample ends up in the top slot
    // and is swapped into the LSBs when the frame is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            frame_sr     <= '0;
            push_pending <= 1'b0;
        end else begin
            push_pending <= 1'b0;
            if (!shift_active) begin
                bit_cnt <= '0;
            end else if (rpi_rise) begin
                frame_sr <= {frame_sr[FRAME_W-2:0], ser_sync[1]};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt      <= '0;
                    push_pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        push_frame = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            push_frame[c*SAMPLE_W +: SAMPLE_W] = frame_sr[(CHANNELS-1-c)*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_DISABLED;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_DISABLED: if (enable) state_next = ST_PRIME;
            ST_PRIME: begin
                if (!enable)                state_next = ST_DISABLED;
                else if (level >= HIGH_LVL) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)           state_next = ST_DISABLED;
                else if (underrun_set) state_next = ST_PRIME;
            end
            default: state_next = ST_DISABLED;
        endcase
    end

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        pop_take     = pop_req && (state == ST_RUN) && !empty;
        underrun_set = pop_req && (state == ST_RUN) && empty;
        push_ok      = push_pending && (!full || pop_take);
        overrun_set  = push_pending && full && !pop_take;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_frame;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            data          <= '0;
            underrun      <= 1'b0;
            overrun       <= 1'b0;
            rpi_interrupt <= 1'b0;
        end else begin
            ready_q  <= ready;
            underrun <= underrun_set;
            overrun  <= overrun_set;
            if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_take) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_take)      level <= level + 1'b1;
            else if (!push_ok && pop_take) level <= level - 1'b1;
            if (pop_req) data <= pop_take ? mem[rd_ptr] : '0;
            if (!enable || state == ST_DISABLED) rpi_interrupt <= 1'b0;
            else if (level < LOW_LVL)            rpi_interrupt <= 1'b1;
            else if (level >= HIGH_LVL)          rpi_interrupt <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_frame_fifo.sv
// tb/tb_serial_frame_fifo.sv - directed self-checking bench for serial_frame_fifo
module tb_serial_frame_fifo;
    logic        clk = 1'b0;
    logic        rst_n, rpi_clk, serial, enable, ready;
    logic        rpi_interrupt, underrun, overrun;
    logic [31:0] data;
    logic [6:0]  level;
    int tests_run = 0, tests_failed = 0, ovr_cnt = 0, und_cnt = 0;

    always #5 clk = ~clk;

    serial_frame_fifo dut (
        .clk(clk), .rst_n(rst_n), .rpi_clk(rpi_clk), .serial(serial), .enable(enable),
        .ready(ready), .rpi_interrupt(rpi_interrupt), .data(data), .level(level),
        .underrun(underrun), .overrun(overrun)
    );

    always begin
        @(posedge clk);
        #2;
        if (overrun)  ovr_cnt++;
        if (underrun) und_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        serial  = b;
        rpi_clk = 1'b0;
        tick(2);
        rpi_clk = 1'b1;
        tick(2);
        rpi_clk = 1'b0;
    endtask

    // Channel 0 first, each sample MSB first.
    task automatic shift_bits(input logic [31:0] f, input int nbits);
        for (int k = 0; k < nbits; k++) shift_bit(f[(k / 16) * 16 + 15 - (k % 16)]);
    endtask

    task automatic send_frame(input logic [31:0] f);
        shift_bits(f, 32);
        tick(3);
    endtask

    task automatic pop();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
    endtask

    function automatic logic [31:0] f_val(input int i);
        return (i == 0) ? 32'hABCD_1234 : (32'h5A00_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] g_val(input int i);
        return 32'hC000_0000 | 32'(i);
    endfunction

    localparam logic [31:0] H_FRAME  = 32'h7777_1111;
    localparam logic [31:0] K1_FRAME = 32'h1111_2222;
    localparam logic [31:0] K2_FRAME = 32'h3333_4444;

    initial begin
        rst_n = 1'b0; rpi_clk = 1'b0; serial = 1'b0; enable = 1'b0; ready = 1'b0;
        tick(2);
        check("rst_level", level, 0);
        check("rst_data", data, 0);
        check("rst_irq", rpi_interrupt, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(2);
        check("disabled_irq", rpi_interrupt, 0);

        // asynchronous reset in the middle of a frame
        enable = 1'b1;
        tick(3);
        check("enabled_irq", rpi_interrupt, 1);
        shift_bits(32'hFFFF_FFFF, 12);
        rst_n = 1'b0;
        #1;
        check("async_rst_irq", rpi_interrupt, 0);
        check("async_rst_level", level, 0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_irq", rpi_interrupt, 1);
        check("post_rst_level", level, 0);

        // stereo load, priming, hysteresis on the way up
        send_frame(f_val(0));
        check("load_level1", level, 1);
        check("load_data_hold", data, 0);
        for (int i = 1; i < 47; i++) send_frame(f_val(i));
        check("level47", level, 47);
        check("irq_at47", rpi_interrupt, 1);
        send_frame(f_val(47));
        check("level48", level, 48);
        check("irq_at48", rpi_interrupt, 0);

        pop();
        check("first_pop_data", data, 32'hABCD_1234);
        check("first_pop_level", level, 47);
        for (int i = 1; i < 32; i++) begin
            pop();
            check("pop_seq_a", data, f_val(i));
        end
        check("level16", level, 16);
        check("irq_at16", rpi_interrupt, 0);
        pop();
        check("level15", level, 15);
        check("irq_at15", rpi_interrupt, 1);
        for (int i = 33; i < 48; i++) begin
            pop();
            check("pop_seq_b", data, f_val(i));
        end
        check("drained_level", level, 0);

        // underrun in RUN, then silence in PRIME
        ready = 1'b1;
        tick(1);
        check("underrun_data", data, 0);
        check("underrun_pulse", underrun, 1);
        ready = 1'b0;
        tick(1);
        check("underrun_cleared", underrun, 0);
        pop();
        check("underrun_count", und_cnt, 1);
        check("prime_pop_data", data, 0);

        // overrun on a full FIFO, then simultaneous pop and push
        for (int i = 0; i < 64; i++) send_frame(g_val(i));
        check("full_level", level, 64);
        check("full_irq", rpi_interrupt, 0);
        send_frame(32'hDEAD_BEEF);
        check("overrun_count", ovr_cnt, 1);
        check("overrun_level", level, 64);
        shift_bits(H_FRAME, 31);
        serial  = H_FRAME[16];
        rpi_clk = 1'b0;
        tick(2);
        rpi_clk = 1'b1;
        tick(2);
        rpi_clk = 1'b0;
        tick(1);
        ready = 1'b1;
        tick(1);
        check("pushpop_level", level, 64);
        check("pushpop_data", data, g_val(0));
        ready = 1'b0;
        tick(2);
        check("pushpop_no_overrun", ovr_cnt, 1);
        for (int i = 1; i <= 64; i++) begin
            pop();
            check("drain", data, (i < 64) ? g_val(i) : H_FRAME);
        end
        check("drain_level", level, 0);
        check("drain_irq", rpi_interrupt, 1);
        check("drain_no_underrun", und_cnt, 1);

        // enable drop mid-frame
        send_frame(K1_FRAME);
        check("k1_level", level, 1);
        shift_bits(32'hFFFF_FFFF, 20);
        enable = 1'b0;
        tick(3);
        check("disable_level", level, 1);
        check("disable_irq", rpi_interrupt, 0);
        pop();
        check("disabled_pop_data", data, 0);
        check("disabled_pop_level", level, 1);
        check("disabled_no_underrun", und_cnt, 1);
        enable = 1'b1;
        tick(3);
        check("reenable_irq", rpi_interrupt, 1);
        send_frame(K2_FRAME);
        check("k2_level", level, 2);
        for (int i = 0; i < 46; i++) send_frame(32'h0F0F_0000 | 32'(i));
        check("refill_level", level, 48);
        pop();
        check("k1_data", data, K1_FRAME);
        pop();
        check("k2_data", data, K2_FRAME);
        check("final_level", level, 46);
        check("final_overrun", ovr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
